fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch front end for the RV32I pipeline. It replaces the single PC register and always-on icache read with a fetch FSM and a DEPTH-entry instruction queue between the icache and decode. Each queue entry carries the instruction, its PC and the branch predictor's sideband bits. Decode stalls by withholding `deq_ready`, so icache traffic and decode back-pressure are decoupled. Mispredict/jump redirects flush the queue and handle an in-flight icache read safely.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `XLEN`, 32: PC width.
- `PRED_W`, 41: width of the opaque predictor sideband (perceptron output, target, hit).
- `RESET_PC`, 32'h0000_0060: first fetch address.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset; asserted when 0.
- `icache_read` out 1: icache request; held until `icache_resp`.
- `icache_addr` out XLEN: fetch address; stable while `icache_read` is high.
- `icache_rdata` in 32: instruction word, valid with `icache_resp`.
- `icache_resp` in 1: request complete.
- `pred_taken` in 1: predictor's taken prediction for `icache_addr` (combinational from `icache_addr`).
- `pred_target` in XLEN: predicted target for `icache_addr`.
- `pred_info` in PRED_W: sideband stored with the entry.
- `redirect` in 1: flush and refetch; from EX/MEM (mispredict, jal, jalr).
- `redirect_pc` in XLEN: new fetch PC.
- `deq_valid` out 1: head entry valid.
- `deq_ready` in 1: decode accepts the head entry.
- `deq_instr` out 32: head instruction.
- `deq_pc` out XLEN: head PC.
- `deq_pred_taken` out 1: head's taken prediction.
- `deq_pred_info` out PRED_W: head's sideband.
- `count` out $clog2(DEPTH+1): current occupancy.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - REQ: request outstanding; the response is kept.
  - DROP: request outstanding; the response is discarded.
- Signals owned by the FSM:
  - `fetch_pc` is a register; `icache_addr = fetch_pc`.
  - `icache_read = (state != IDLE)`.
- IDLE transitions:
  - `redirect`: `fetch_pc <= redirect_pc`; stay IDLE.
  - Otherwise, if `count < DEPTH`, go to REQ.
- REQ transitions:
  - `icache_resp` && !`redirect`: enqueue {rdata, fetch_pc, pred_taken, pred_info}.
    - `fetch_pc <= pred_taken ? pred_target : fetch_pc+4` (mod 2^XLEN).
    - Next state is REQ if post-update count < DEPTH, else IDLE.
  - `icache_resp` && `redirect`: discard the response; `fetch_pc <= redirect_pc`; go to REQ.
  - !`icache_resp` && `redirect`: `fetch_pc_next <= redirect_pc`; go to DROP. `icache_addr` stays at the old PC until the response.
- DROP transitions:
  - `icache_resp`: discard; `fetch_pc <= fetch_pc_next`; go to REQ.
  - `redirect` without response: overwrite `fetch_pc_next`; stay DROP.
  - `redirect` with response: load the new `redirect_pc` directly; go to REQ.
- Redirect side effects:
  - `redirect_pc[1:0]` is forced to 0.
  - Flushes the queue: `count <= 0`, head = tail.
  - Takes priority over enqueue and dequeue in the same cycle; `deq_ready` is ignored.
- Queue:
  - Circular buffer with $clog2(DEPTH)-bit head/tail pointers that wrap.
  - `deq_valid = (count != 0)`; head fields are driven from the storage array.
  - Dequeue occurs when `deq_valid && deq_ready && !redirect`.
  - A request is issued only when `count < DEPTH`, and at most one is in flight, so enqueue never overflows.
  - Simultaneous enqueue and dequeue leaves `count` unchanged.

## Timing
- Reset (asserted): `state`=IDLE, `fetch_pc`=RESET_PC, `count`=0, pointers 0. Outputs: `icache_read`=0, `icache_addr`=RESET_PC, `deq_valid`=0; entry contents are don't-care.
- First cycle after reset release: still IDLE; `icache_read` rises the following cycle with `icache_addr`=RESET_PC.
- Response in cycle N: the entry is visible at `deq_valid` in N+1 (no bypass). The next request is issued in N+1 (back-to-back) if space remains.
- Steady-state throughput is one instruction per icache response; the REQ→REQ path has no bubble.
- Redirect in cycle N with no request in flight: `icache_addr`=redirect_pc from N+1.
- Redirect in cycle N while in flight: the new address is presented in the cycle after the in-flight response.
- Queue full in IDLE: the FSM stays in IDLE until a dequeue, then goes to REQ in the next cycle.

## Test plan
- Reset release with icache_resp every 2nd cycle and deq_ready=1 -> addresses 0x60, 0x64, 0x68 in order; deq_pc follows the same sequence, each deq_valid appearing one cycle after its resp.
- Hold deq_ready=0 with DEPTH=4 -> exactly 4 responses accepted, count=4, icache_read=0. Raise deq_ready for one cycle -> count=3, then icache_read=1 the next cycle.
- At fetch_pc=0x80, pred_taken=1, pred_target=0x200 -> next icache_addr=0x200; that entry's deq_pred_taken=1 and deq_pred_info matches the sampled value.
- Redirect to 0x140 while a request for 0x70 is outstanding, resp 3 cycles later -> icache_addr stays 0x70 until resp; the data is not enqueued, count=0, and the next icache_addr is 0x140.
- Redirect coinciding with resp and deq_ready=1 on a 2-entry queue -> count=0, no entry enqueued, next icache_addr=redirect_pc.
- Assert rst low mid-DROP -> icache_read=0, count=0 immediately (asynchronous); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: icache request/response, predictor lookup, redirect, decode dequeue.
interface fetch_queue_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PRED_W = 41,
  parameter int unsigned CNT_W  = 3
);
  logic              icache_read;
  logic [XLEN-1:0]   icache_addr;
  logic [31:0]       icache_rdata;
  logic              icache_resp;
  logic              pred_taken;
  logic [XLEN-1:0]   pred_target;
  logic [PRED_W-1:0] pred_info;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;
  logic              deq_valid;
  logic              deq_ready;
  logic [31:0]       deq_instr;
  logic [XLEN-1:0]   deq_pc;
  logic              deq_pred_taken;
  logic [PRED_W-1:0] deq_pred_info;
  logic [CNT_W-1:0]  count;

  modport master (
    output icache_read, icache_addr,
    input  icache_rdata, icache_resp,
    input  pred_taken, pred_target, pred_info,
    input  redirect, redirect_pc,
    output deq_valid, deq_instr, deq_pc, deq_pred_taken, deq_pred_info, count,
    input  deq_ready
  );

  modport slave (
    input  icache_read, icache_addr,
    output icache_rdata, icache_resp,
    output pred_taken, pred_target, pred_info,
    output redirect, redirect_pc,
    input  deq_valid, deq_instr, deq_pc, deq_pred_taken, deq_pred_info, count,
    output deq_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch FSM feeding a DEPTH-entry queue between icache and decode.
module fetch_queue #(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     PRED_W   = 41,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0060)
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);
  localparam int unsigned      PTR_W = $clog2(DEPTH);
  localparam int unsigned      CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

  typedef struct packed {
    logic [31:0]       instr;
    logic [XLEN-1:0]   pc;
    logic              taken;
    logic [PRED_W-1:0] info;
  } entry_t;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, count_post;
  entry_t           mem_q [DEPTH];
  entry_t           enq_ent, head_ent;
  logic             enq, deq;
  logic [XLEN-1:0]  redir_pc;

  // Fetch FSM: request sequencing, next-PC selection, in-flight redirect handling
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    enq        = 1'b0;
    redir_pc   = bus.redirect_pc & ~XLEN'(3);
    deq        = (count_q != '0) && bus.deq_ready && !bus.redirect;
    count_post = count_q + CNT_W'(1) - CNT_W'(deq);
    enq_ent    = '{instr: bus.icache_rdata, pc: fetch_pc_q,
                   taken: bus.pred_taken, info: bus.pred_info};
    unique case (state_q)
      IDLE: begin
        if (bus.redirect)        fetch_pc_d = redir_pc;
        else if (count_q < FULL) state_d    = REQ;
      end
      REQ: begin
        if (bus.icache_resp) begin
          if (bus.redirect) begin
            fetch_pc_d = redir_pc;
          end else begin
            enq        = 1'b1;
            fetch_pc_d = bus.pred_taken ? bus.pred_target : fetch_pc_q + XLEN'(4);
            state_d    = (count_post < FULL) ? REQ : IDLE;
          end
        end else if (bus.redirect) begin
          // keep presenting the old address until its response drains
          pend_pc_d = redir_pc;
          state_d   = DROP;
        end
      end
      DROP: begin
        if (bus.icache_resp) begin
          fetch_pc_d = bus.redirect ? redir_pc : pend_pc_q;
          state_d    = REQ;
        end else if (bus.redirect) begin
          pend_pc_d = redir_pc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Queue pointers and occupancy; redirect flushes and wins over enq/deq
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.redirect) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PTR_W'(1);
      if (deq) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Entry storage; contents need no reset
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= enq_ent;
  end

  assign head_ent           = mem_q[head_q];
  assign bus.icache_read    = (state_q != IDLE);
  assign bus.icache_addr    = fetch_pc_q;
  assign bus.deq_valid      = (count_q != '0);
  assign bus.deq_instr      = head_ent.instr;
  assign bus.deq_pc         = head_ent.pc;
  assign bus.deq_pred_taken = head_ent.taken;
  assign bus.deq_pred_info  = head_ent.info;
  assign bus.count          = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fetch order, back-pressure, prediction, redirects, reset.
module tb_fetch_queue;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;
  logic [31:0] taken_pc;
  logic [31:0] taken_tgt;

  fetch_queue_if #(.XLEN(32), .PRED_W(41), .CNT_W(3)) bus ();

  fetch_queue #(.DEPTH(4), .XLEN(32), .PRED_W(41), .RESET_PC(32'h0000_0060)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // icache data and predictor models, both functions of the presented address
  always_comb begin
    bus.icache_rdata = bus.icache_addr ^ 32'hDEAD_0000;
    bus.pred_taken   = (bus.icache_addr == taken_pc);
    bus.pred_target  = taken_tgt;
    bus.pred_info    = {9'h1AB, bus.icache_addr};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total         = 0;
    n_bad           = 0;
    rst_n           = 1'b0;
    taken_pc        = 32'hFFFF_FFF0;
    taken_tgt       = 32'h0;
    bus.icache_resp = 1'b0;
    bus.deq_ready   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    tick(); tick();

    check("rst_read",  64'(bus.icache_read), 64'd0);
    check("rst_addr",  64'(bus.icache_addr), 64'h60);
    check("rst_valid", 64'(bus.deq_valid),   64'd0);
    check("rst_count", 64'(bus.count),       64'd0);

    rst_n = 1'b1;
    check("first_idle", 64'(bus.icache_read), 64'd0);
    tick();
    check("first_read", 64'(bus.icache_read), 64'd1);
    check("first_addr", 64'(bus.icache_addr), 64'h60);

    // sequential fetch, resp every other cycle, decode always ready
    bus.deq_ready = 1'b1;
    tick();
    check("hold_addr", 64'(bus.icache_addr), 64'h60);
    bus.icache_resp = 1'b1; tick(); bus.icache_resp = 1'b0;
    check("seq0_valid", 64'(bus.deq_valid),   64'd1);
    check("seq0_pc",    64'(bus.deq_pc),      64'h60);
    check("seq0_instr", 64'(bus.deq_instr),   64'hDEAD_0060);
    check("seq0_next",  64'(bus.icache_addr), 64'h64);
    tick();
    check("seq0_drain", 64'(bus.count), 64'd0);
    bus.icache_resp = 1'b1; tick(); bus.icache_resp = 1'b0;
    check("seq1_pc",   64'(bus.deq_pc),      64'h64);
    check("seq1_next", 64'(bus.icache_addr), 64'h68);
    tick();
    bus.icache_resp = 1'b1; tick(); bus.icache_resp = 1'b0;
    check("seq2_pc",   64'(bus.deq_pc),      64'h68);
    check("seq2_next", 64'(bus.icache_addr), 64'h6C);
    tick();
    bus.deq_ready = 1'b0;
    check("seq2_drain", 64'(bus.count), 64'd0);

    // fill the queue with decode stalled
    bus.icache_resp = 1'b1;
    repeat (4) tick();
    bus.icache_resp = 1'b0;
    check("full_count", 64'(bus.count),       64'd4);
    check("full_read",  64'(bus.icache_read), 64'd0);
    check("full_head",  64'(bus.deq_pc),      64'h6C);
    tick();
    check("full_hold_count", 64'(bus.count),       64'd4);
    check("full_hold_read",  64'(bus.icache_read), 64'd0);
    bus.deq_ready = 1'b1; tick(); bus.deq_ready = 1'b0;
    check("deq1_count", 64'(bus.count),       64'd3);
    check("deq1_read",  64'(bus.icache_read), 64'd0);
    check("deq1_head",  64'(bus.deq_pc),      64'h70);
    tick();
    check("refetch_read", 64'(bus.icache_read), 64'd1);
    check("refetch_addr", 64'(bus.icache_addr), 64'h7C);
    bus.deq_ready = 1'b1;
    repeat (3) tick();
    bus.deq_ready = 1'b0;
    check("drain_count", 64'(bus.count), 64'd0);

    // taken prediction at 0x80 steers fetch to 0x200
    taken_pc  = 32'h80;
    taken_tgt = 32'h200;
    bus.icache_resp = 1'b1;
    tick();
    check("pred_pre_addr", 64'(bus.icache_addr), 64'h80);
    tick();
    bus.icache_resp = 1'b0;
    check("pred_addr",      64'(bus.icache_addr),    64'h200);
    check("pred_count",     64'(bus.count),          64'd2);
    check("pred_nt_head",   64'(bus.deq_pred_taken), 64'd0);
    bus.deq_ready = 1'b1;
    tick();
    check("pred_head_pc",   64'(bus.deq_pc),         64'h80);
    check("pred_head_tk",   64'(bus.deq_pred_taken), 64'd1);
    check("pred_head_info", 64'(bus.deq_pred_info),  64'({9'h1AB, 32'h0000_0080}));
    tick();
    bus.deq_ready = 1'b0;
    check("pred_drain", 64'(bus.count), 64'd0);

    // redirect while in flight; low PC bits are cleared
    bus.redirect = 1'b1; bus.redirect_pc = 32'h71;
    tick();
    bus.redirect = 1'b0;
    check("drop_addr_old", 64'(bus.icache_addr), 64'h200);
    check("drop_read",     64'(bus.icache_read), 64'd1);
    bus.icache_resp = 1'b1; tick(); bus.icache_resp = 1'b0;
    check("drop_new_addr", 64'(bus.icache_addr), 64'h70);
    check("drop_discard",  64'(bus.count),       64'd0);

    bus.redirect = 1'b1; bus.redirect_pc = 32'h140;
    tick();
    bus.redirect = 1'b0;
    check("r140_hold0", 64'(bus.icache_addr), 64'h70);
    tick();
    check("r140_hold1", 64'(bus.icache_addr), 64'h70);
    tick();
    check("r140_hold2", 64'(bus.icache_addr), 64'h70);
    check("r140_read",  64'(bus.icache_read), 64'd1);
    bus.icache_resp = 1'b1; tick(); bus.icache_resp = 1'b0;
    check("r140_addr",  64'(bus.icache_addr), 64'h140);
    check("r140_count", 64'(bus.count),       64'd0);
    check("r140_valid", 64'(bus.deq_valid),   64'd0);

    // redirect coincides with resp and dequeue on a two-entry queue
    bus.icache_resp = 1'b1;
    tick(); tick();
    check("two_count", 64'(bus.count), 64'd2);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h300; bus.deq_ready = 1'b1;
    tick();
    bus.icache_resp = 1'b0; bus.redirect = 1'b0; bus.deq_ready = 1'b0;
    check("coinc_count", 64'(bus.count),       64'd0);
    check("coinc_valid", 64'(bus.deq_valid),   64'd0);
    check("coinc_addr",  64'(bus.icache_addr), 64'h300);
    check("coinc_read",  64'(bus.icache_read), 64'd1);

    // asynchronous reset in the middle of DROP
    bus.redirect = 1'b1; bus.redirect_pc = 32'h400;
    tick();
    bus.redirect = 1'b0;
    check("pre_rst_addr", 64'(bus.icache_addr), 64'h300);
    #2 rst_n = 1'b0;
    #1;
    check("arst_read",  64'(bus.icache_read), 64'd0);
    check("arst_count", 64'(bus.count),       64'd0);
    check("arst_addr",  64'(bus.icache_addr), 64'h60);
    #2 rst_n = 1'b1;
    tick();
    check("restart_read",  64'(bus.icache_read), 64'd1);
    check("restart_addr",  64'(bus.icache_addr), 64'h60);
    check("restart_valid", 64'(bus.deq_valid),   64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
